audio_capture: RTL and testbench

- Recording counterpart of the ROM-playback path: takes 16-bit samples from the audio codec interface on each `sample_end` strobe and writes them into a dual-port sample RAM.
- Armed and aborted through a 4-bit control word from the Avalon bus.
- Recording starts immediately or on a level trigger. It stops after DEPTH samples.
- Status outputs tell software when the buffer is ready to be read back.

---
 rtl/audio_pkg.sv | 13 +
 rtl/audio_level_detect.sv | 25 ++
 rtl/audio_capture.sv | 99 +++++++++
 tb/tb_audio_capture.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio record/playback blocks.
package audio_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, RECORD, DONE} cap_state_t;

  localparam int unsigned CTL_ARM   = 0;
  localparam int unsigned CTL_ABORT = 1;
  localparam int unsigned CTL_TRIG  = 2;

  localparam int unsigned AUDIO_ADDR_W = 15;
  localparam int unsigned AUDIO_DEPTH  = 22050;

endpackage

// File: rtl/audio_level_detect.sv
// Saturating magnitude of a signed 16-bit sample compared against a threshold.
module audio_level_detect
  import audio_pkg::*;
#(
  parameter logic [15:0] TRIG_LEVEL = 16'd1024
) (
  input  logic [15:0] sample,
  output logic        hit
);

  logic [15:0] mag;

  always_comb begin
    // -32768 has no positive counterpart; clamp it to full scale.
    if (sample == 16'h8000) begin
      mag = 16'h7fff;
    end else if (sample[15]) begin
      mag = ~sample + 16'd1;
    end else begin
      mag = sample;
    end
    hit = (mag >= TRIG_LEVEL);
  end

endmodule

// File: rtl/audio_capture.sv
// Records codec samples into a sample RAM after an arm command, optionally
// waiting for a level trigger, and stops after DEPTH samples.
module audio_capture
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_W     = AUDIO_ADDR_W,
  parameter int unsigned DEPTH      = AUDIO_DEPTH,
  parameter logic [15:0] TRIG_LEVEL = 16'd1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_end,
  input  logic [15:0]       audio_sample,
  input  logic [3:0]        control,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sample_count
);

  localparam logic [ADDR_W:0] LastCount = (ADDR_W+1)'(DEPTH);

  cap_state_t      state_q;
  logic            control0_q;
  logic            hit;
  logic            arm_rise;
  logic [ADDR_W:0] count_inc;
  logic            unused_ctl;

  assign arm_rise   = control[CTL_ARM] & ~control0_q;
  assign count_inc  = {1'b0, sample_count} + (ADDR_W+1)'(1);
  assign unused_ctl = control[3];

  audio_level_detect #(
    .TRIG_LEVEL (TRIG_LEVEL)
  ) u_level_detect (
    .sample (audio_sample),
    .hit    (hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      control0_q   <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_en        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_count <= '0;
    end else begin
      control0_q <= control[CTL_ARM];
      wr_en      <= 1'b0;
      if (control[CTL_ABORT]) begin
        state_q <= IDLE;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            // A strobe coinciding with the arm edge is deliberately dropped.
            if (arm_rise) begin
              sample_count <= '0;
              busy         <= 1'b1;
              done         <= 1'b0;
              state_q      <= control[CTL_TRIG] ? WAIT_TRIG : RECORD;
            end
          end
          WAIT_TRIG: begin
            if (sample_end && hit) begin
              wr_en        <= 1'b1;
              wr_addr      <= '0;
              wr_data      <= audio_sample;
              sample_count <= ADDR_W'(1);
              state_q      <= RECORD;
            end
          end
          RECORD: begin
            if (sample_end) begin
              wr_en        <= 1'b1;
              wr_addr      <= sample_count;
              wr_data      <= audio_sample;
              sample_count <= count_inc[ADDR_W-1:0];
              if (count_inc == LastCount) begin
                state_q <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_capture.sv
// Randomised self-checking bench for audio_capture against a rule-level model.
module tb_audio_capture;

  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_end = 1'b0;
  logic [15:0] audio_sample = '0;
  logic [3:0]  control;
  logic        arm_lvl = 1'b0, abort_lvl = 1'b0, trig_lvl = 1'b0;

  logic [3:0]  wr_addr0, wr_addr1, cnt0, cnt1;
  logic [15:0] wr_data0, wr_data1;
  logic        wr_en0, wr_en1, busy0, busy1, done0, done1;

  int vectors = 0;
  int miscompares = 0;

  // Model state: 0 idle, 1 waiting for trigger, 2 recording, 3 done.
  int          m_st = 0;
  int          m_cnt = 0;
  logic [3:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic        m_we = 1'b0;
  logic        m_arm_prev = 1'b0;

  assign control = {1'b0, trig_lvl, abort_lvl, arm_lvl};

  wire [26:0] obs0 = {wr_en0, wr_addr0, wr_data0, busy0, done0, cnt0};
  wire [26:0] obs1 = {wr_en1, wr_addr1, wr_data1, busy1, done1, cnt1};

  always #5 clk = ~clk;

  audio_capture #(.ADDR_W(4), .DEPTH(Depth), .TRIG_LEVEL(16'd1024)) dut0 (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_end   (sample_end),
    .audio_sample (audio_sample),
    .control      (control),
    .wr_addr      (wr_addr0),
    .wr_data      (wr_data0),
    .wr_en        (wr_en0),
    .busy         (busy0),
    .done         (done0),
    .sample_count (cnt0)
  );

  audio_capture #(.ADDR_W(4), .DEPTH(Depth), .TRIG_LEVEL(16'd32767)) dut1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_end   (sample_end),
    .audio_sample (audio_sample),
    .control      (control),
    .wr_addr      (wr_addr1),
    .wr_data      (wr_data1),
    .wr_en        (wr_en1),
    .busy         (busy1),
    .done         (done1),
    .sample_count (cnt1)
  );

  function automatic int mag(logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return s;
  endfunction

  function automatic logic [26:0] exp_vec();
    logic [3:0] c;
    c = m_cnt[3:0];
    return {m_we, m_addr, m_data, (m_st == 1 || m_st == 2), (m_st == 3), c};
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_addr = '0; m_data = '0; m_we = 1'b0; m_arm_prev = 1'b0;
  endtask

  task automatic model_write(int addr, logic [15:0] v);
    m_we = 1'b1;
    m_addr = addr[3:0];
    m_data = v;
  endtask

  // One clock: drive inputs, apply the capture rules, return just after the edge.
  task automatic tick(logic se, logic [15:0] v);
    logic rise;
    @(negedge clk);
    sample_end = se;
    audio_sample = v;
    rise = arm_lvl && !m_arm_prev;
    m_arm_prev = arm_lvl;
    m_we = 1'b0;
    if (abort_lvl) begin
      m_st = 0;
    end else if ((m_st == 0 || m_st == 3) && rise) begin
      m_cnt = 0;
      m_st = trig_lvl ? 1 : 2;
    end else if (se && m_st == 1 && mag(v) >= 1024) begin
      model_write(0, v);
      m_cnt = 1;
      m_st = 2;
    end else if (se && m_st == 2) begin
      model_write(m_cnt, v);
      m_cnt++;
      if (m_cnt == Depth) m_st = 3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #7;
    vectors++;
    if (obs0 !== 27'd0 || obs1 !== 27'd0) begin
      miscompares++;
      $display("FAIL reset: got %h/%h want 0", obs0, obs1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    tick(1'b0, 16'h0);
    vectors++;
    if (obs0 !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_idle: got %h want %h", obs0, exp_vec());
    end
  endtask

  task automatic test_immediate();
    trig_lvl = 1'b0;
    arm_lvl = 1'b1;
    tick(1'b1, 16'h1234);  // strobe coincides with arm edge: not recorded
    vectors++;
    if (obs0 !== exp_vec() || wr_en0 !== 1'b0) begin
      miscompares++;
      $display("FAIL imm_arm: got %h want %h", obs0, exp_vec());
    end
    arm_lvl = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick(1'b1, 16'(i));
      vectors++;
      if (obs0 !== exp_vec()) begin
        miscompares++;
        $display("FAIL imm_write%0d: got %h want %h", i, obs0, exp_vec());
      end
      tick(1'b0, 16'hdead);
      vectors++;
      if (obs0 !== exp_vec()) begin
        miscompares++;
        $display("FAIL imm_gap%0d: got %h want %h", i, obs0, exp_vec());
      end
    end
    vectors++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 4'd8) begin
      miscompares++;
      $display("FAIL imm_done: got done=%b busy=%b cnt=%0d want 1 0 8", done0, busy0, cnt0);
    end
  endtask

  task automatic test_level_trigger();
    logic [15:0] seq [11];
    seq[0] = 16'd100; seq[1] = 16'hfc01; seq[2] = 16'd1023; seq[3] = 16'hfc00;
    for (int i = 4; i < 11; i++) seq[i] = 16'($urandom);
    trig_lvl = 1'b1;
    arm_lvl = 1'b0;
    tick(1'b0, 16'h0);
    arm_lvl = 1'b1;
    tick(1'b0, 16'h0);
    for (int i = 0; i < 11; i++) begin
      tick(1'b1, seq[i]);
      vectors++;
      if (obs0 !== exp_vec()) begin
        miscompares++;
        $display("FAIL trig_s%0d: got %h want %h", i, obs0, exp_vec());
      end
      tick(1'b0, 16'h0);
    end
    vectors++;
    if (done0 !== 1'b1 || cnt0 !== 4'd8) begin
      miscompares++;
      $display("FAIL trig_done: got done=%b cnt=%0d want 1 8", done0, cnt0);
    end
  endtask

  task automatic test_saturation();
    test_reset();
    trig_lvl = 1'b1;
    arm_lvl = 1'b1;
    tick(1'b0, 16'h0);
    tick(1'b1, 16'h8001);  // magnitude 32767: hits
    tick(1'b0, 16'h0);
    test_reset();
    arm_lvl = 1'b0;
    tick(1'b0, 16'h0);
    arm_lvl = 1'b1;
    tick(1'b0, 16'h0);
    tick(1'b1, 16'h7ffe);
    vectors++;
    if (wr_en1 !== 1'b0 || busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_below: got en=%b busy=%b want 0 1", wr_en1, busy1);
    end
    tick(1'b0, 16'h0);
    tick(1'b1, 16'h8000);
    vectors++;
    if (wr_en1 !== 1'b1 || wr_addr1 !== 4'd0 || wr_data1 !== 16'h8000 || cnt1 !== 4'd1) begin
      miscompares++;
      $display("FAIL sat_hit: got en=%b addr=%0d data=%h cnt=%0d want 1 0 8000 1",
               wr_en1, wr_addr1, wr_data1, cnt1);
    end
    tick(1'b0, 16'h0);
  endtask

  task automatic test_abort();
    trig_lvl = 1'b0;
    arm_lvl = 1'b0;
    tick(1'b0, 16'h0);
    arm_lvl = 1'b1;
    tick(1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 16'($urandom));
      tick(1'b0, 16'h0);
    end
    abort_lvl = 1'b1;
    tick(1'b1, 16'h5555);
    vectors++;
    if (obs0 !== exp_vec() || wr_en0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: got %h want %h", obs0, exp_vec());
    end
    abort_lvl = 1'b0;
    arm_lvl = 1'b0;
    tick(1'b0, 16'h0);
    arm_lvl = 1'b1;
    tick(1'b0, 16'h0);
    tick(1'b1, 16'h0abc);
    vectors++;
    if (obs0 !== exp_vec() || wr_addr0 !== 4'd0 || wr_en0 !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_restart: got %h want %h", obs0, exp_vec());
    end
    tick(1'b0, 16'h0);
  endtask

  task automatic test_rearm();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 16'($urandom));
      tick(1'b0, 16'h0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 16'h0);
      vectors++;
      if (obs0 !== exp_vec() || done0 !== 1'b1) begin
        miscompares++;
        $display("FAIL rearm_hold%0d: got %h want %h", i, obs0, exp_vec());
      end
    end
    arm_lvl = 1'b0;
    tick(1'b0, 16'h0);
    arm_lvl = 1'b1;
    tick(1'b0, 16'h0);
    vectors++;
    if (obs0 !== exp_vec() || cnt0 !== 4'd0 || busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL rearm_restart: got %h want %h", obs0, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 16'h7777);
    tick(1'b0, 16'h0);
    tick(1'b1, 16'h1111);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (obs0 !== 27'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want 0", obs0);
    end
    model_reset();
    arm_lvl = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick(1'b1, 16'h2222);
    vectors++;
    if (obs0 !== exp_vec()) begin
      miscompares++;
      $display("FAIL async_idle: got %h want %h", obs0, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int cap = 0; cap < 40; cap++) begin
      trig_lvl = 1'($urandom);
      arm_lvl = 1'b0;
      tick(1'b0, 16'h0);
      arm_lvl = 1'b1;
      for (int s = 0; s < 14; s++) begin
        v = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 2047)) - 16'd1024
                                         : 16'($urandom);
        abort_lvl = ($urandom_range(0, 39) == 0);
        tick(($urandom_range(0, 3) != 0), v);
        vectors++;
        if (obs0 !== exp_vec()) begin
          miscompares++;
          $display("FAIL rand_c%0d_s%0d: got %h want %h", cap, s, obs0, exp_vec());
        end
        abort_lvl = 1'b0;
        for (int g = 0; g < $urandom_range(1, 3); g++) begin
          tick(1'b0, 16'($urandom));
          vectors++;
          if (obs0 !== exp_vec()) begin
            miscompares++;
            $display("FAIL rand_gap_c%0d_s%0d: got %h want %h", cap, s, obs0, exp_vec());
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_level_trigger();
    test_saturation();
    test_abort();
    test_rearm();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
